comb_decim_ctrl: RTL

COMB_DECIM_CTRL -- requirements
Module: comb_decim_ctrl

---
 rtl/comb_decim_ctrl_if.sv | 30 +++
 rtl/comb_decim_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/comb_decim_ctrl_if.sv
// Bundle of configuration, sample-stream, comb-datapath and status signals for comb_decim_ctrl.
// The controller uses the slave view; the environment driving samples and hosting the datapath uses master.
interface comb_decim_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int OUT_W   = 17,
    parameter int RATIO_W = 5
);
    logic                      cfg_en;
    logic        [RATIO_W-1:0] cfg_ratio;
    logic                      in_valid;
    logic signed [DATA_W-1:0]  in_data;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  comb_in;
    logic signed [OUT_W-1:0]   comb_out;
    logic                      out_valid;
    logic signed [OUT_W-1:0]   out_data;
    logic                      busy;
    logic                      cfg_err;
    logic        [15:0]        out_cnt;

    modport master (
        output cfg_en, cfg_ratio, in_valid, in_data, comb_out,
        input  in_ready, comb_in, out_valid, out_data, busy, cfg_err, out_cnt
    );

    modport slave (
        input  cfg_en, cfg_ratio, in_valid, in_data, comb_out,
        output in_ready, comb_in, out_valid, out_data, busy, cfg_err, out_cnt
    );
endinterface

// File: rtl/comb_decim_ctrl.sv
// Decimation controller for an external pipelined comb datapath: accepts samples, zero-stuffs
// bubbles, tracks samples through the datapath with a tag pipe and emits every R-th result.
module comb_decim_ctrl #(
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 17,
    parameter int PIPE_LAT = 3,
    parameter int RATIO_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    comb_decim_ctrl_if.slave  bus
);
    localparam int TAG_D = PIPE_LAT + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                    state_reg, state_next;
    logic        [RATIO_W-1:0] ratio_reg, ratio_next;
    logic        [RATIO_W-1:0] phase_reg, phase_next;
    logic        [TAG_D-1:0]   tag_reg, tag_next;
    logic signed [DATA_W-1:0]  comb_in_reg, comb_in_next;
    logic signed [OUT_W-1:0]   out_data_reg, out_data_next;
    logic                      out_valid_reg, out_valid_next;
    logic                      cfg_err_reg, cfg_err_next;
    logic        [15:0]        out_cnt_reg, out_cnt_next;

    logic ratio_legal;
    logic start;
    logic drain_done;
    logic accept;
    logic tag_hit;
    logic phase_last;
    logic emit;

    assign ratio_legal = (bus.cfg_ratio >= RATIO_W'(2)) && (bus.cfg_ratio <= RATIO_W'(16));
    assign accept      = bus.in_valid && (state_reg == RUN);
    assign tag_hit     = tag_reg[PIPE_LAT];
    assign phase_last  = (phase_reg == (ratio_reg - RATIO_W'(1)));
    assign emit        = tag_hit && phase_last;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cfg_err_reg <= 1'b0;
            ratio_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= cfg_err_next;
            ratio_reg   <= ratio_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cfg_err_next = cfg_err_reg;
        ratio_next   = ratio_reg;
        start        = 1'b0;
        drain_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cfg_en) begin
                    if (ratio_legal) begin
                        state_next   = RUN;
                        start        = 1'b1;
                        cfg_err_next = 1'b0;
                        ratio_next   = bus.cfg_ratio;
                    end else begin
                        cfg_err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!bus.cfg_en) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once every sample in flight has reached the phase logic.
                if (tag_reg == '0) begin
                    state_next = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Tag pipe: bit gi follows the sample that entered comb_in gi edges ago
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < TAG_D; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_next[gi] = accept;
            end else begin : g_body
                assign tag_next[gi] = tag_reg[gi-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sample path, phase counter and output registers
    // ------------------------------------------------------------------
    always_comb begin
        comb_in_next   = accept ? bus.in_data : '0;
        phase_next     = phase_reg;
        out_valid_next = emit;
        out_data_next  = emit ? bus.comb_out : out_data_reg;
        out_cnt_next   = out_cnt_reg;

        if (start || drain_done) begin
            phase_next = '0;
        end else if (tag_hit) begin
            phase_next = phase_last ? '0 : (phase_reg + RATIO_W'(1));
        end

        if (start) begin
            out_cnt_next = '0;
        end else if (emit && (out_cnt_reg != 16'hFFFF)) begin
            out_cnt_next = out_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_reg       <= '0;
            comb_in_reg   <= '0;
            phase_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_cnt_reg   <= '0;
        end else begin
            tag_reg       <= tag_next;
            comb_in_reg   <= comb_in_next;
            phase_reg     <= phase_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_cnt_reg   <= out_cnt_next;
        end
    end

    assign bus.in_ready  = (state_reg == RUN);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.comb_in   = comb_in_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.cfg_err   = cfg_err_reg;
    assign bus.out_cnt   = out_cnt_reg;

endmodule
